// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared fixed-point constants and FSM encoding for the FIR MAC sequencer
package fir_pkg;

  localparam int WIDTH     = 23;
  localparam int PRESICION = 14;
  localparam int TAPS      = 8;
  localparam int ADDRW     = 3;

  // Symmetric saturation bounds; the most-negative code is never produced
  localparam logic signed [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MINV = {1'b1, {(WIDTH-2){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fir_mac_sequencer_sat_add.sv
// rtl/fir_mac_sequencer_sat_add.sv - signed saturating adder with symmetric clamp
module sat_add import fir_pkg::*; #(
  parameter int Width = WIDTH
) (
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  output logic [Width-1:0] y
);

  // Bounds widened by one bit so the raw sum can be compared without overflow
  localparam logic signed [Width:0] MAX_EXT = {2'b00, {(Width-1){1'b1}}};
  localparam logic signed [Width:0] MIN_EXT = {2'b11, {(Width-2){1'b0}}, 1'b1};

  logic signed [Width:0] sum;

  // form the sum one bit wider, then clamp into [MINV, MAXV]
  always_comb begin
    sum = $signed({a[Width-1], a}) + $signed({b[Width-1], b});
    if (sum > MAX_EXT) begin
      y = MAX_EXT[Width-1:0];
    end else if (sum < MIN_EXT) begin
      y = MIN_EXT[Width-1:0];
    end else begin
      y = sum[Width-1:0];
    end
  end

endmodule

// File: rtl/fir_mac_sequencer.sv
// rtl/fir_mac_sequencer.sv - time-multiplexed FIR controller driving one shared multiplier
module fir_mac_sequencer import fir_pkg::*; #(
  parameter int Width     = WIDTH,
  parameter int Presicion = PRESICION,
  parameter int Taps      = TAPS,
  parameter int AddrW     = ADDRW
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [Width-1:0] sample_in,
  input  logic             sample_valid,
  output logic             in_ready,
  input  logic             coef_we,
  input  logic [AddrW-1:0] coef_addr,
  input  logic [Width-1:0] coef_data,
  output logic [Width-1:0] mult_a,
  output logic [Width-1:0] mult_b,
  input  logic [Width-1:0] mult_y,
  output logic [Width-1:0] y_out,
  output logic             y_valid,
  output logic             overrun,
  input  logic             clear_ovf
);

  // The fixed-point format only has to agree with the external multiplier
  if (AddrW != $clog2(Taps) || Taps < 2 || Taps > 64 || Presicion >= Width) begin : g_bad_params
    $error("fir_mac_sequencer: inconsistent Width/Presicion/Taps/AddrW");
  end

  state_t           state;
  state_t           state_next;
  logic [Width-1:0] x [Taps];
  logic [Width-1:0] h [Taps];
  logic [Width-1:0] acc;
  logic [Width-1:0] acc_sum;
  logic [AddrW-1:0] k;
  logic             last_tap;
  logic             accept;
  logic             coef_ok;

  assign last_tap = (k == AddrW'(Taps - 1));
  assign accept   = (state == ST_IDLE) && sample_valid;
  assign coef_ok  = (int'(coef_addr) < Taps);

  sat_add #(.Width(Width)) u_acc_add (
    .a (acc),
    .b (mult_y),
    .y (acc_sum)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // next state plus multiplier operands; operands held at 0 outside MAC
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    mult_a     = '0;
    mult_b     = '0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (sample_valid) begin
          state_next = ST_MAC;
        end
      end
      ST_MAC: begin
        mult_a = x[k];
        mult_b = h[k];
        if (last_tap) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // delay line shifts once per accepted sample
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < Taps; i++) begin
        x[i] <= '0;
      end
    end else if (accept) begin
      x[0] <= sample_in;
      for (int i = 1; i < Taps; i++) begin
        x[i] <= x[i-1];
      end
    end
  end

  // coefficient bank is writable only while idle, so a running MAC sees stable taps
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < Taps; i++) begin
        h[i] <= '0;
      end
    end else if ((state == ST_IDLE) && coef_we && coef_ok) begin
      h[coef_addr] <= coef_data;
    end
  end

  // accumulate one saturated tap product per MAC cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
      k   <= '0;
    end else if (accept) begin
      acc <= '0;
      k   <= '0;
    end else if (state == ST_MAC) begin
      acc <= acc_sum;
      k   <= k + 1'b1;
    end
  end

  // publish the result and track dropped samples (a drop beats a clear)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      y_out   <= '0;
      y_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      y_valid <= (state == ST_DONE);
      if (state == ST_DONE) begin
        y_out <= acc;
      end
      if (sample_valid && (state != ST_IDLE)) begin
        overrun <= 1'b1;
      end else if (clear_ovf) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb/tb_fir_mac_sequencer.sv - table-driven and randomized bench for fir_mac_sequencer
`timescale 1ns/1ps
module tb_fir_mac_sequencer;
  import fir_pkg::*;

  localparam int W   = WIDTH;
  localparam int P   = PRESICION;
  localparam int T   = TAPS;
  localparam int LAT = T + 2;
  localparam longint MAXL = longint'(MAXV);
  localparam logic [W-1:0] POS_M = MAXV;
  localparam logic [W-1:0] NEG_M = MINV;
  localparam logic [W-1:0] ONE   = W'(16384);
  localparam logic [W-1:0] HALF  = W'(8192);
  localparam logic [W-1:0] NONE  = W'(-16384);

  logic         clk;
  logic         reset_n;
  logic [W-1:0] sample_in;
  logic         sample_valid;
  logic         in_ready;
  logic         coef_we;
  logic [2:0]   coef_addr;
  logic [W-1:0] coef_data;
  logic [W-1:0] mult_a;
  logic [W-1:0] mult_b;
  logic [W-1:0] mult_y;
  logic [W-1:0] y_out;
  logic         y_valid;
  logic         overrun;
  logic         clear_ovf;

  int checks;
  int errors;

  typedef struct {
    logic [W-1:0] sample;
    logic [W-1:0] exp_y;
  } vec_t;
  vec_t tbl[$];

  logic [W-1:0] m_hist [T];
  logic [W-1:0] m_coef [T];
  logic [W-1:0] y_got;
  int           nv;

  fir_mac_sequencer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .in_ready     (in_ready),
    .coef_we      (coef_we),
    .coef_addr    (coef_addr),
    .coef_data    (coef_data),
    .mult_a       (mult_a),
    .mult_b       (mult_b),
    .mult_y       (mult_y),
    .y_out        (y_out),
    .y_valid      (y_valid),
    .overrun      (overrun),
    .clear_ovf    (clear_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint sx(input logic [W-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint clampl(input longint v);
    if (v > MAXL) return MAXL;
    if (v < -MAXL) return -MAXL;
    return v;
  endfunction

  function automatic logic [W-1:0] fx_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    p = (sx(a) * sx(b)) >>> P;
    return W'(clampl(p));
  endfunction

  // shared saturating multiplier living beside the DUT
  always_comb mult_y = fx_mul(mult_a, mult_b);

  // reference: dot product folded tap by tap with saturation after every add
  function automatic logic [W-1:0] ref_y();
    longint acc;
    acc = 0;
    for (int i = 0; i < T; i++) begin
      acc = clampl(acc + sx(fx_mul(m_hist[i], m_coef[i])));
    end
    return W'(acc);
  endfunction

  function automatic logic [W-1:0] rnd_word();
    int s;
    case ($urandom_range(0, 3))
      0: return W'($urandom);
      1: return ($urandom_range(0, 1) != 0) ? POS_M : NEG_M;
      default: begin
        s = int'($urandom_range(0, 65535)) - 32768;
        return W'(s);
      end
    endcase
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_push(input logic [W-1:0] s);
    for (int i = T - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = s;
  endtask

  task automatic m_clear();
    for (int i = 0; i < T; i++) begin
      m_hist[i] = '0;
      m_coef[i] = '0;
    end
  endtask

  task automatic do_reset();
    sample_valid = 1'b0;
    coef_we      = 1'b0;
    clear_ovf    = 1'b0;
    reset_n      = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    m_clear();
  endtask

  task automatic wr_coef(input logic [2:0] a, input logic [W-1:0] d);
    coef_we   = 1'b1;
    coef_addr = a;
    coef_data = d;
    tick();
    coef_we   = 1'b0;
    m_coef[a] = d;
  endtask

  // one sample (optionally with a same-cycle coefficient write) through to y_valid
  task automatic run_sample(input logic [W-1:0] s, input logic we, input logic [2:0] a,
                            input logic [W-1:0] d, output logic [W-1:0] y);
    int n;
    bit found;
    sample_in    = s;
    sample_valid = 1'b1;
    coef_we      = we;
    coef_addr    = a;
    coef_data    = d;
    if (we) m_coef[a] = d;
    m_push(s);
    tick();
    sample_valid = 1'b0;
    coef_we      = 1'b0;
    n = 0;
    found = 1'b0;
    while (!found && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 2) check("in_ready_busy", longint'(in_ready), 0);
      if (y_valid) found = 1'b1;
    end
    check("latency", found ? n : -1, LAT);
    y = y_out;
    @(negedge clk);
    check("y_valid_width", longint'(y_valid), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < tbl.size(); i++) begin
      run_sample(tbl[i].sample, 1'b0, 3'd0, '0, y_got);
      check(name, sx(y_got), sx(tbl[i].exp_y));
    end
    tbl.delete();
  endtask

  // wait for results of an already-started computation, counting y_valid pulses
  task automatic drain(input int cycles);
    nv = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (y_valid) begin
        nv++;
        y_got = y_out;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks       = 0;
    errors       = 0;
    reset_n      = 1'b0;
    sample_in    = '0;
    sample_valid = 1'b0;
    coef_we      = 1'b0;
    coef_addr    = '0;
    coef_data    = '0;
    clear_ovf    = 1'b0;
    y_got        = '0;
    do_reset();

    // reset state
    @(negedge clk);
    check("rst_in_ready", longint'(in_ready), 1);
    check("rst_y_valid", longint'(y_valid), 0);
    check("rst_y_out", sx(y_out), 0);
    check("rst_overrun", longint'(overrun), 0);
    check("rst_mult_a", sx(mult_a), 0);
    check("rst_mult_b", sx(mult_b), 0);
    @(posedge clk);
    #1;

    // impulse response
    wr_coef(3'd0, ONE);
    wr_coef(3'd1, HALF);
    tbl.push_back('{ONE, ONE});
    tbl.push_back('{W'(0), HALF});
    tbl.push_back('{W'(0), W'(0)});
    run_table("impulse");

    // positive and negative rail saturation
    do_reset();
    for (int a = 0; a < T; a++) wr_coef(3'(a), ONE);
    for (int i = 0; i < T; i++) tbl.push_back('{POS_M, POS_M});
    run_table("sat_pos");
    do_reset();
    for (int a = 0; a < T; a++) wr_coef(3'(a), ONE);
    for (int i = 0; i < T; i++) tbl.push_back('{NEG_M, NEG_M});
    run_table("sat_neg");

    // step-wise saturation: clamp at MAXV then pulled back to 0
    do_reset();
    wr_coef(3'd0, ONE);
    wr_coef(3'd1, ONE);
    wr_coef(3'd2, NONE);
    tbl.push_back('{POS_M, POS_M});
    tbl.push_back('{POS_M, POS_M});
    tbl.push_back('{POS_M, W'(0)});
    run_table("sat_order");

    // overrun: second sample three cycles later is dropped
    do_reset();
    wr_coef(3'd0, ONE);
    sample_in = W'(1000);
    sample_valid = 1'b1;
    m_push(W'(1000));
    tick();
    sample_valid = 1'b0;
    tick();
    tick();
    sample_in = W'(7777);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    drain(17);
    check("ovr_one_result", nv, 1);
    check("ovr_result", sx(y_got), sx(ref_y()));
    check("ovr_flag", longint'(overrun), 1);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    @(negedge clk);
    check("ovr_cleared", longint'(overrun), 0);
    @(posedge clk);
    #1;
    sample_in = W'(5);
    sample_valid = 1'b1;
    m_push(W'(5));
    tick();
    sample_valid = 1'b0;
    tick();
    sample_valid = 1'b1;
    clear_ovf = 1'b1;
    tick();
    sample_valid = 1'b0;
    clear_ovf = 1'b0;
    @(negedge clk);
    check("ovr_set_wins", longint'(overrun), 1);
    drain(14);
    check("ovr2_one_result", nv, 1);
    check("ovr2_result", sx(y_got), sx(ref_y()));

    // coefficient write during MAC is ignored
    do_reset();
    wr_coef(3'd0, ONE);
    sample_in = ONE;
    sample_valid = 1'b1;
    m_push(ONE);
    tick();
    sample_valid = 1'b0;
    tick();
    coef_we = 1'b1;
    coef_addr = 3'd0;
    coef_data = NONE;
    tick();
    coef_we = 1'b0;
    drain(15);
    check("busy_wr_result", sx(y_got), 16384);
    run_sample(HALF, 1'b0, 3'd0, '0, y_got);
    check("busy_wr_readback", sx(y_got), 8192);
    run_sample(W'(4096), 1'b1, 3'd0, NONE, y_got);
    check("idle_wr_same_cycle", sx(y_got), -4096);

    // reset in the middle of MAC at k=3
    do_reset();
    for (int a = 0; a < T; a++) wr_coef(3'(a), ONE);
    run_sample(W'(100), 1'b0, 3'd0, '0, y_got);
    run_sample(W'(200), 1'b0, 3'd0, '0, y_got);
    run_sample(W'(300), 1'b0, 3'd0, '0, y_got);
    check("pre_reset_sum", sx(y_got), 600);
    sample_in = W'(400);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    tick();
    tick();
    tick();
    @(negedge clk);
    check("k3_mult_a", sx(mult_a), 100);
    #1;
    reset_n = 1'b0;
    m_clear();
    #1;
    check("midrst_y_out", sx(y_out), 0);
    tick();
    tick();
    reset_n = 1'b1;
    drain(15);
    check("midrst_no_valid", nv, 0);
    check("midrst_in_ready", longint'(in_ready), 1);
    check("midrst_y_out_after", sx(y_out), 0);
    for (int a = 0; a < T; a++) wr_coef(3'(a), ONE);
    run_sample(ONE, 1'b0, 3'd0, '0, y_got);
    check("midrst_clean_history", sx(y_got), 16384);

    // randomized against the reference model
    do_reset();
    for (int a = 0; a < T; a++) wr_coef(3'(a), rnd_word());
    for (int it = 0; it < 120; it++) begin
      case ($urandom_range(0, 4))
        0: wr_coef(3'($urandom_range(0, T - 1)), rnd_word());
        1: begin
          run_sample(rnd_word(), 1'b1, 3'($urandom_range(0, T - 1)), rnd_word(), y_got);
          check("random_wr", sx(y_got), sx(ref_y()));
        end
        default: begin
          run_sample(rnd_word(), 1'b0, 3'd0, '0, y_got);
          check("random", sx(y_got), sx(ref_y()));
        end
      endcase
    end
    @(negedge clk);
    check("idle_mult_a", sx(mult_a), 0);
    check("idle_mult_b", sx(mult_b), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
Time-multiplexed FIR controller that shares one saturating fixed-point multiplier (Q(Width-Presicion-1).Presicion, signed) across all taps. Each accepted input sample is shifted into an internal delay line. The block then issues one tap product per clock to the external multiplier and accumulates the results with symmetric saturation. It sits between the sample source (ADC side) and the output stage (DAC side), and it is the sole driver of the multiplier's A/B inputs.

Parameters:
Width, 23, total signed word width of samples, coefficients, products and output.
Presicion, 14, fractional bits. Fixed-point format must match the shared multiplier.
Taps, 8, number of FIR taps (2..64).
AddrW, 3, coefficient address width; must equal clog2(Taps).

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
sample_in  in  Width  signed input sample.
sample_valid  in  1  one-cycle strobe; sample_in valid this cycle.
in_ready  out  1  high when IDLE and able to accept a sample.
coef_we  in  1  coefficient write strobe.
coef_addr  in  AddrW  tap index to write.
coef_data  in  Width  signed coefficient value.
mult_a  out  Width  operand A to the shared multiplier (delay-line sample).
mult_b  out  Width  operand B to the shared multiplier (coefficient).
mult_y  in  Width  saturated product returned combinationally by the multiplier.
y_out  out  Width  registered filter output.
y_valid  out  1  one-cycle pulse; y_out updated.
overrun  out  1  sticky flag: a sample was dropped.
clear_ovf  in  1  synchronous clear of overrun.

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE; delay line, coefficient bank, acc, k, y_out all 0; y_valid=0; overrun=0. Reset mid-MAC aborts the computation, produces no y_valid, and clears history.
- Constants: MAXV = 2^(Width-1)-1; MINV = -(2^(Width-1)-1). Saturation is symmetric, and the most-negative code is never produced.
- FSM IDLE -> MAC -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On sample_valid: x[0]<=sample_in, x[i]<=x[i-1] for i=1..Taps-1; acc<=0; k<=0; go to MAC.
- MAC:
  - mult_a=x[k], mult_b=h[k], driven combinationally from registered k.
  - Each cycle: acc <= sat(acc + mult_y), with the sum formed at Width+1 bits then clamped to [MINV, MAXV].
  - k increments each cycle; on k==Taps-1 go to DONE.
- DONE: y_out<=acc; y_valid<=1 for the next cycle only; go to IDLE.
- Outside MAC, mult_a and mult_b are driven to 0 so the multiplier idles at 0.
- Latency: sample_valid in cycle 0 -> MAC in cycles 1..Taps -> DONE in cycle Taps+1 -> y_valid high in cycle Taps+2. Throughput is one sample per Taps+2 cycles.
- sample_valid while not IDLE: the sample is dropped and overrun<=1 (sticky). If clear_ovf and a drop occur in the same cycle, set wins.
- Coefficient writes are accepted only in IDLE: h[coef_addr]<=coef_data. A write in MAC or DONE is ignored. If coef_we and sample_valid occur in the same IDLE cycle, both are performed, and the new coefficient is used for this sample.
- coef_addr >= Taps: write ignored.
- The accumulator saturates step-wise, so a later opposite-sign product can pull it back from the rail. This order-dependent behaviour is required and must be modelled by the bench.

Decomposition:
- Shared package/include (fir_pkg): Width, Presicion, MAXV/MINV, and the FSM state encodings (IDLE=2'd0, MAC=2'd1, DONE=2'd2).
- Natural sub-module: sat_add (Width-bit signed saturating adder, combinational), reused for the accumulator. The delay line and coefficient bank stay inline as register arrays.
- The multiplier is instantiated beside this block by the parent, not inside it.

Test Plan:
1. Impulse: h[0]=16384 (1.0), h[1]=8192 (0.5), others 0; samples 16384, 0, 0 -> y_out = 16384, 8192, 0, each y_valid exactly Taps+2 cycles after its sample_valid.
2. Positive saturation: all h=16384; 8 samples of 4194303 -> final y_out = 4194303 (MAXV), no wrap. Negative mirror with -4194303 -> y_out = -4194303 (MINV), never -4194304.
3. Overrun: sample_valid in cycles 0 and 3 -> second sample dropped, overrun=1, exactly one y_valid. Then clear_ovf -> overrun=0. Clear and drop in the same cycle -> overrun stays 1.
4. Coefficient write while busy: write h[0]=-16384 during MAC -> ignored. The next output is computed with the old h[0], and a read-back via an impulse test confirms this.
5. Reset mid-operation: deassert reset_n at MAC k=3 -> no y_valid, y_out=0, in_ready=1 after release; next impulse shows a cleared history.
6. Step-wise saturation order: h={16384,16384,-16384,0...}; history x[0]=x[1]=4194303, x[2]=4194303 -> acc clamps at MAXV, then subtracts to 0 -> y_out=0 (not 4194303).
